// File: rtl/pipeline_hazard_controller.sv
// Central hazard controller for the five-stage core: drives stall/bubble/nullify/keep_exception
// for the four pipeline registers (k: 0=F/D, 1=D/E, 2=E/M, 3=M/W) and counts lost cycles.
module pipeline_hazard_controller #(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_uses_rs,
  input  logic        d_uses_rt,
  input  logic        d_branch_use,
  input  logic [4:0]  ex_dest_reg,
  input  logic [4:0]  mem_dest_reg,
  input  logic        ex_writes,
  input  logic        ex_is_load,
  input  logic        mem_is_load,
  input  logic        ex_mdu_op,
  input  logic        ex_mdu_div,
  input  logic        ex_uses_hilo,
  input  logic        mem_busy,
  input  logic        mem_exception,
  output logic        pc_stall,
  output logic [3:0]  stall,
  output logic [3:0]  bubble,
  output logic [3:0]  nullify,
  output logic [3:0]  keep_exception,
  output logic        mdu_busy,
  output logic [31:0] perf_stall_cycles
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  mdu_count;
  logic [31:0] perf_cnt;
  logic        mdu_start;
  logic        decode_hazard;
  logic        mdu_hazard;

  // A source only matters if decode actually reads it and it is not the hard-wired zero register.
  function automatic logic src_hazard(input logic [4:0] r, input logic used,
                                      input logic branch_use,
                                      input logic [4:0] ex_dest, input logic ex_wr,
                                      input logic ex_ld,
                                      input logic [4:0] mem_dest, input logic mem_ld);
    logic live;
    live = used && (r != 5'd0);
    return live && ((ex_ld && (ex_dest == r)) ||
                    (branch_use && ex_wr && (ex_dest == r)) ||
                    (branch_use && mem_ld && (mem_dest == r)));
  endfunction

  assign decode_hazard =
    src_hazard(d_rs, d_uses_rs, d_branch_use, ex_dest_reg, ex_writes, ex_is_load,
               mem_dest_reg, mem_is_load) ||
    src_hazard(d_rt, d_uses_rt, d_branch_use, ex_dest_reg, ex_writes, ex_is_load,
               mem_dest_reg, mem_is_load);

  assign mdu_busy   = (mdu_count != 6'd0);
  assign mdu_hazard = mdu_busy && (ex_mdu_op || ex_uses_hilo);
  assign mdu_start  = (state_q == ST_RUN) && ex_mdu_op && !mdu_busy &&
                      !mem_exception && !mem_busy;
  assign perf_stall_cycles = perf_cnt;

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    pc_stall       = 1'b0;
    stall          = 4'b0000;
    bubble         = 4'b0000;
    nullify        = 4'b0000;
    keep_exception = 4'b0000;
    unique case (state_q)
      ST_BOOT: begin
        nullify = 4'b1111;
        state_d = ST_RUN;
      end
      ST_FLUSH: begin
        nullify = 4'b0001;
        state_d = ST_RUN;
      end
      default: begin
        if (mem_exception) begin
          nullify        = 4'b0111;
          keep_exception = 4'b1000;
          state_d        = ST_FLUSH;
        end else if (mem_busy) begin
          pc_stall = 1'b1;
          stall    = 4'b0111;
          bubble   = 4'b1000;
        end else if (mdu_hazard) begin
          pc_stall = 1'b1;
          stall    = 4'b0011;
          bubble   = 4'b0100;
        end else if (decode_hazard) begin
          pc_stall = 1'b1;
          stall    = 4'b0001;
          bubble   = 4'b0010;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      mdu_count <= 6'd0;
      perf_cnt  <= 32'd0;
    end else begin
      state_q <= state_d;
      // The countdown keeps running through exceptions and flushes; the unit cannot be aborted.
      if (mdu_start)
        mdu_count <= ex_mdu_div ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);
      else if (mdu_busy)
        mdu_count <= mdu_count - 6'd1;
      if ((state_q == ST_RUN) && (pc_stall || (bubble != 4'b0000)))
        perf_cnt <= perf_cnt + 32'd1;
    end
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Drives the controller side of every `pipeline_interface` in the five-stage core (nullify, stall, bubble, keep_exception), replacing per-stage ad-hoc hazard logic. It detects load-use and branch-operand hazards, memory wait, multiply/divide busy, and exception flush. It tracks multiply/divide occupancy with an internal countdown. It also counts lost cycles for performance monitoring. Register index k: 0 = F/D, 1 = D/E, 2 = E/M, 3 = M/W.

## Interface
- MUL_CYCLES, 3: busy cycles after a multiply start (1..63)
- DIV_CYCLES, 32: busy cycles after a divide start (1..63)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- d_rs, d_rt  in  5 each  decode source registers
- d_uses_rs, d_uses_rt  in  1 each  decode reads rs/rt at execute
- d_branch_use  in  1  decode reads rs/rt in decode (branch/jr compare)
- ex_dest_reg, mem_dest_reg  in  5 each  destination of execute/memory stage
- ex_writes, ex_is_load, mem_is_load  in  1 each  stage writes GPR / is a load
- ex_mdu_op, ex_mdu_div, ex_uses_hilo  in  1 each  execute holds mult/div, it is a divide, reads hi/lo
- mem_busy  in  1  data memory not ready
- mem_exception  in  1  memory-stage instruction raised exception
- pc_stall  out  1  PC register holds
- stall, bubble, nullify, keep_exception  out  4 each  per-register controls (bit k = register k)
- mdu_busy  out  1  countdown nonzero
- perf_stall_cycles  out  32  cycles with any stall or bubble asserted, wraps

## Operation
- States: BOOT, RUN, FLUSH. Reset → BOOT; BOOT → RUN unconditionally; RUN → FLUSH on mem_exception; FLUSH → RUN unconditionally.
- BOOT: nullify=4'b1111, all else 0.
- FLUSH: nullify=4'b0001, all else 0. Hazard inputs ignored (downstream stages hold bubbles).
- RUN priority, highest first; only the winning cause drives outputs:
  - Exception (mem_exception): nullify=4'b0111, keep_exception=4'b1000, pc_stall=0. mem_busy is ignored.
  - Memory wait (mem_busy): pc_stall=1, stall=4'b0111, bubble=4'b1000.
  - MDU (mdu_busy and (ex_mdu_op or ex_uses_hilo)): pc_stall=1, stall=4'b0011, bubble=4'b0100.
  - Decode hazard: pc_stall=1, stall=4'b0001, bubble=4'b0010. Raised when any of these holds, with r = d_rs or d_rt and its use bit set, and r≠0:
    - ex_is_load, ex_dest_reg==r (execute-use);
    - d_branch_use, ex_writes, ex_dest_reg==r;
    - d_branch_use, mem_is_load, mem_dest_reg==r.
  - None: all outputs 0.
- MDU countdown (6 bits):
  - A start is accepted when state=RUN, ex_mdu_op, count==0, no exception, no mem_busy.
  - On acceptance, load DIV_CYCLES if ex_mdu_div, else MUL_CYCLES.
  - Otherwise decrement while nonzero, in every state including FLUSH; exceptions do not abort it.
- mdu_busy = (count≠0).
- perf_stall_cycles increments in RUN when pc_stall or any bubble bit is 1, and wraps at 2^32−1 → 0. It is not incremented in BOOT or FLUSH.

## Timing
- All control outputs are combinational from registered state, count, and same-cycle inputs. There is no output latency.
- State, count, and perf counter update on the rising edge of clk.
- Reset asserted, asynchronously:
  - state=BOOT, count=0, perf=0;
  - outputs: nullify=4'b1111, stall=bubble=keep_exception=0, pc_stall=0, mdu_busy=0.
- First cycle after release is BOOT, then RUN.
- MDU start accepted in cycle N: mdu_busy=1 from N+1 through N+MUL/DIV_CYCLES, and 0 at N+CYCLES+1.
- Reset mid-countdown clears count immediately.
- Exception together with decode hazard: exception wins. The hazard re-evaluates after FLUSH.
- mem_busy held for K cycles: pipeline frozen for exactly K cycles and perf counter advances by K.

## Test plan
- Reset release → cycle 0 nullify=1111, cycle 1 all outputs 0, perf=0.
- Load-use: ex_is_load=1, ex_dest_reg=8, d_rs=8, d_uses_rs=1 → pc_stall=1, stall=0001, bubble=0010. Same with d_rs=0 → no stall.
- Divide: accept with DIV_CYCLES=32, next cycle ex_uses_hilo=1 → stall=0011, bubble=0100 for 32 cycles; released on cycle 33; perf=32.
- mem_busy for 5 cycles with a concurrent decode hazard → stall=0111, bubble=1000 each cycle; then the decode hazard outputs appear.
- mem_exception with mem_busy=1 → nullify=0111, keep_exception=1000. Next cycle FLUSH nullify=0001, then RUN with all outputs 0.
- Perf wrap: preset via 2^32−1 stall cycles (or force) → one more stall cycle reads 0.
